// File: rtl/time_report_tx.sv
// Serialises a snapshot of the clock, alarm or countdown registers into a
// 6-byte frame (sync, id, big, middle, less, xor checksum) for the UART TX byte port.
module time_report_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter logic [7:0] ID_BASE   = 8'hA0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] sel,
  input  logic [6:0] Less_clock,
  input  logic [6:0] Middle_clock,
  input  logic [6:0] Big_clock,
  input  logic [6:0] Less_ala,
  input  logic [6:0] Middle_ala,
  input  logic [6:0] Big_ala,
  input  logic [6:0] Less_cla,
  input  logic [6:0] Middle_cla,
  input  logic [6:0] Big_cla,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SYNC, ID, BIG, MID, LESS, SUM} state_t;

  state_t     state;
  logic [1:0] sel_q;
  logic [6:0] big_q, mid_q, less_q;
  logic [7:0] csum;
  logic [6:0] big_src, mid_src, less_src;
  logic       xfer;

  assign xfer = tx_valid && tx_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    big_src  = Big_clock;
    mid_src  = Middle_clock;
    less_src = Less_clock;
    case (sel)
      2'd2: begin
        big_src  = Big_ala;
        mid_src  = Middle_ala;
        less_src = Less_ala;
      end
      2'd3: begin
        big_src  = Big_cla;
        mid_src  = Middle_cla;
        less_src = Less_cla;
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] id_byte(input logic [1:0] s);
    return ID_BASE | {6'b0, s};
  endfunction

  // The byte for the next state is loaded on the handshake that leaves the
  // current one, so tx_data is always a register and simply holds during a stall.
  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      big_q    <= 7'd0;
      mid_q    <= 7'd0;
      less_q   <= 7'd0;
      csum     <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (sel == 2'd0) begin
              err <= 1'b1;
            end else begin
              big_q    <= big_src;
              mid_q    <= mid_src;
              less_q   <= less_src;
              sel_q    <= sel;
              csum     <= id_byte(sel);
              tx_data  <= SYNC_BYTE;
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= SYNC;
            end
          end
        end
        SYNC: if (xfer) begin
          tx_data <= id_byte(sel_q);
          state   <= ID;
        end
        ID: if (xfer) begin
          tx_data <= {1'b0, big_q};
          state   <= BIG;
        end
        BIG: if (xfer) begin
          tx_data <= {1'b0, mid_q};
          csum    <= csum ^ {1'b0, big_q};
          state   <= MID;
        end
        MID: if (xfer) begin
          tx_data <= {1'b0, less_q};
          csum    <= csum ^ {1'b0, mid_q};
          state   <= LESS;
        end
        LESS: if (xfer) begin
          tx_data <= csum ^ {1'b0, less_q};
          csum    <= csum ^ {1'b0, less_q};
          state   <= SUM;
        end
        SUM: if (xfer) begin
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_report_tx.sv
// Self-checking bench for time_report_tx: frames captured from the byte handshake
// are compared against frames computed from the time values with plain arithmetic.
module tb_time_report_tx;

  logic       clk = 1'b0;
  logic       rst, req, tx_ready;
  logic [1:0] sel;
  logic [6:0] Less_clock, Middle_clock, Big_clock;
  logic [6:0] Less_ala, Middle_ala, Big_ala;
  logic [6:0] Less_cla, Middle_cla, Big_cla;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Capture results of the most recent collect() call.
  logic [7:0] got_q[$];
  int stall_bad, sync_cyc, done_cyc, err_seen;
  logic busy_at_sync, busy_at_done, valid_at_done;

  always #5 clk = ~clk;

  time_report_tx dut (
    .clk(clk), .rst(rst), .req(req), .sel(sel),
    .Less_clock(Less_clock), .Middle_clock(Middle_clock), .Big_clock(Big_clock),
    .Less_ala(Less_ala), .Middle_ala(Middle_ala), .Big_ala(Big_ala),
    .Less_cla(Less_cla), .Middle_cla(Middle_cla), .Big_cla(Big_cla),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Reference frame: sync, id, three zero-extended fields, xor of id and fields.
  function automatic logic [7:0] exp_byte(input int i, input logic [1:0] s,
                                          input logic [6:0] b, input logic [6:0] m,
                                          input logic [6:0] l);
    logic [7:0] id;
    id = 8'hA0 + {6'd0, s};
    case (i)
      0: return 8'h55;
      1: return id;
      2: return {1'b0, b};
      3: return {1'b0, m};
      4: return {1'b0, l};
      default: return id ^ {1'b0, b} ^ {1'b0, m} ^ {1'b0, l};
    endcase
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  // Steps negedges after an accepting edge until done (bounded), recording
  // transferred bytes and stall behaviour. mode 0: ready high, 1: 1,0,0 pattern,
  // 2: random. req stays high for cycles c < hold_n.
  task automatic collect(input int mode, input int hold_n);
    logic       pv, pr;
    logic [7:0] pd;
    int         k;
    got_q = {};
    stall_bad = 0; sync_cyc = -1; done_cyc = -1; err_seen = 0;
    busy_at_sync = 1'b0; busy_at_done = 1'b1; valid_at_done = 1'b1;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; k = 0;
    for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
      @(negedge clk);
      req = (c < hold_n);
      if (pv && pr) got_q.push_back(pd);
      if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stall_bad++;
      if (err === 1'b1) err_seen++;
      if (tx_valid === 1'b1 && sync_cyc < 0) begin
        sync_cyc = c;
        busy_at_sync = busy;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        busy_at_done = busy;
        valid_at_done = tx_valid;
      end
      pv = tx_valid; pd = tx_data;
      case (mode)
        0: tx_ready = 1'b1;
        1: begin tx_ready = (k % 3 == 0); k++; end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      pr = tx_ready;
    end
  endtask

  task automatic set_src(input logic [1:0] s, input logic [6:0] b, input logic [6:0] m,
                         input logic [6:0] l);
    case (s)
      2'd1: begin Big_clock = b; Middle_clock = m; Less_clock = l; end
      2'd2: begin Big_ala = b; Middle_ala = m; Less_ala = l; end
      2'd3: begin Big_cla = b; Middle_cla = m; Less_cla = l; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; sel = 2'd0; tx_ready = 1'b1;
    {Big_clock, Middle_clock, Less_clock} = '0;
    {Big_ala, Middle_ala, Less_ala} = '0;
    {Big_cla, Middle_cla, Less_cla} = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_content();
    set_src(2'd1, 7'd23, 7'd45, 7'd12);
    sel = 2'd1; req = 1'b1; tx_ready = 1'b1;
    collect(0, 1);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL content_len got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_at(i) !== exp_byte(i, 2'd1, 7'd23, 7'd45, 7'd12)) begin
        errors++; $display("FAIL content_byte%0d got %h want %h", i, got_at(i), exp_byte(i, 2'd1, 7'd23, 7'd45, 7'd12));
      end
    end
    checks++; if (sync_cyc != 1) begin errors++; $display("FAIL content_latency got %0d want 1", sync_cyc); end
    checks++; if (busy_at_sync !== 1'b1) begin errors++; $display("FAIL content_busy got %b want 1", busy_at_sync); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL content_done_cycle got %0d want 7", done_cyc); end
    checks++; if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin
      errors++; $display("FAIL content_done_idle got busy=%b valid=%b want 0 0", busy_at_done, valid_at_done);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL content_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    logic [1:0] s;
    logic [6:0] b, m, l;
    set_src(2'd2, 7'd7, 7'd30, 7'd0);
    sel = 2'd2; req = 1'b1; tx_ready = 1'b1;
    collect(1, 1);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_len got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_at(i) !== exp_byte(i, 2'd2, 7'd7, 7'd30, 7'd0)) begin
        errors++; $display("FAIL bp_byte%0d got %h want %h", i, got_at(i), exp_byte(i, 2'd2, 7'd7, 7'd30, 7'd0));
      end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_hold got %0d bad stalls want 0", stall_bad); end
    // Random sources, values (including 127) and random ready.
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      s = 2'($urandom_range(1, 3));
      b = (t == 0) ? 7'd127 : 7'($urandom);
      m = 7'($urandom); l = (t == 1) ? 7'd127 : 7'($urandom);
      set_src(s, b, m, l);
      sel = s; req = 1'b1;
      collect(2, 1);
      checks++;
      if (got_q.size() != 6 || stall_bad != 0) begin
        errors++; $display("FAIL rand%0d_shape got len=%0d stalls=%0d want 6 0", t, got_q.size(), stall_bad);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_at(i) !== exp_byte(i, s, b, m, l)) begin
          errors++; $display("FAIL rand%0d_byte%0d got %h want %h", t, i, got_at(i), exp_byte(i, s, b, m, l));
        end
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    @(negedge clk);
    set_src(2'd3, 7'd1, 7'd2, 7'd3);
    sel = 2'd3; req = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    set_src(2'd3, 7'd0, 7'd0, 7'd0);
    collect(0, 1);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL snap_len got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_at(i) !== exp_byte(i, 2'd3, 7'd1, 7'd2, 7'd3)) begin
        errors++; $display("FAIL snap_byte%0d got %h want %h", i, got_at(i), exp_byte(i, 2'd3, 7'd1, 7'd2, 7'd3));
      end
    end
  endtask

  task automatic test_invalid_and_busy();
    int extra;
    @(negedge clk);
    sel = 2'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err got %b want 1", err); end
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL invalid_idle got valid=%b busy=%b want 0 0", tx_valid, busy);
    end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_err_width got %b want 0", err); end
    // Frame with invalid-select and valid-select requests arriving while busy.
    set_src(2'd1, 7'd5, 7'd6, 7'd7);
    sel = 2'd1; req = 1'b1;
    @(posedge clk); #1;
    sel = 2'd0;
    collect(0, 4);
    sel = 2'd2;
    checks++; if (err_seen != 0) begin errors++; $display("FAIL busy_req_err got %0d want 0", err_seen); end
    checks++; if (got_at(5) !== exp_byte(5, 2'd1, 7'd5, 7'd6, 7'd7) || got_q.size() != 6) begin
      errors++; $display("FAIL busy_req_frame got %h want %h", got_at(5), exp_byte(5, 2'd1, 7'd5, 7'd6, 7'd7));
    end
    set_src(2'd2, 7'd9, 7'd9, 7'd9);
    sel = 2'd1; req = 1'b1;
    @(posedge clk); #1;
    sel = 2'd2;
    collect(0, 6);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_req_extra_frame got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    set_src(2'd1, 7'd11, 7'd22, 7'd33);
    @(negedge clk);
    sel = 2'd1; req = 1'b1; tx_ready = 1'b1;
    repeat (4) begin @(negedge clk); req = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got valid=%b busy=%b want 0 0", tx_valid, busy);
    end
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1 || err === 1'b1 || tx_valid === 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet got %0d bad cycles want 0", bad); end
    // rst and req together: request dropped.
    sel = 2'd1; req = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_req_drop got valid=%b busy=%b want 0 0", tx_valid, busy);
    end
    set_src(2'd1, 7'd40, 7'd50, 7'd60);
    sel = 2'd1; req = 1'b1;
    collect(0, 1);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL midrst_new_len got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_at(i) !== exp_byte(i, 2'd1, 7'd40, 7'd50, 7'd60)) begin
        errors++; $display("FAIL midrst_new_byte%0d got %h want %h", i, got_at(i), exp_byte(i, 2'd1, 7'd40, 7'd50, 7'd60));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] b, m, l;
    @(negedge clk);
    b = 7'($urandom); m = 7'($urandom); l = 7'($urandom);
    set_src(2'd1, b, m, l);
    sel = 2'd1; req = 1'b1; tx_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      collect(0, (f == 3) ? 7 : 1000);
      checks++; if (sync_cyc != 1 || done_cyc != 7) begin
        errors++; $display("FAIL b2b%0d_timing got start=%0d done=%0d want 1 7", f, sync_cyc, done_cyc);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_at(i) !== exp_byte(i, 2'd1, b, m, l)) begin
          errors++; $display("FAIL b2b%0d_byte%0d got %h want %h", f, i, got_at(i), exp_byte(i, 2'd1, b, m, l));
        end
      end
      b = 7'($urandom); m = 7'($urandom); l = 7'($urandom);
      set_src(2'd1, b, m, l);
    end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_stop got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_frame_content();
    test_backpressure();
    test_snapshot();
    test_invalid_and_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
